mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-requester arbiter that shares the single-port 8-bit data memory / memory-mapped IO block between the CPU datapath (requester 0) and a second bus master such as a DMA or sample-capture engine (requester 1). It drives the memory's ADDR/DATA/MW inputs and returns its combinational read data (Q) to the winning requester as a registered response. Arbitration is round-robin with an optional bounded lock for bursts.

## Interface
- MAX_BURST, 4: maximum consecutive accepted accesses a locked owner may take while the other requester waits; legal range 1–15.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ0, REQ1  in  1  access request from requester n.
- WE0, WE1  in  1  1 = write, 0 = read; qualified by REQn.
- ADDR0, ADDR1  in  8  access address.
- WDATA0, WDATA1  in  8  write data.
- LOCK0, LOCK1  in  1  owner asks to keep the bus for a burst.
- GNT0, GNT1  out  1  combinational from state; requester n owns the bus this cycle.
- ACK0, ACK1  out  1  registered; the access accepted at the previous edge has completed.
- RDATA0, RDATA1  out  8  registered read data; valid when ACKn = 1 and the access was a read; holds otherwise.
- M_ADDR  out  8  memory address.
- M_DATA  out  8  memory write data.
- M_MW  out  1  memory write enable.
- M_Q  in  8  memory read data (combinational from M_ADDR).
- OWNER  out  2  00 idle, 01 requester 0, 10 requester 1.

## Operation
- States: IDLE, OWN0, OWN1. Registers: state, LAST (last owner, 1 bit), BEATS (4 bits), ACKn, RDATAn.
- GNTn = (state == OWNn). OWNER encodes state.
- Memory mux: in OWNn, M_ADDR = ADDRn and M_DATA = WDATAn. In IDLE, M_ADDR = 0 and M_DATA = 0.
- M_MW = GNTn & REQn & WEn & ~RESET.
- Accept: an access is accepted at the rising edge where GNTn & REQn. At that edge:
  - ACKn <= 1;
  - if the access is a read, RDATAn <= M_Q;
  - a write commits in memory on the same edge.
- ACKn <= 0 at every edge with no accept for n.
- IDLE transitions:
  - no requests: stay in IDLE.
  - one requester active: go to its OWN state.
  - both active: go to OWN of ~LAST.
  - No access occurs in an IDLE cycle.
- OWNn with REQn = 1 (accept occurs):
  - Handover when other REQ & (~LOCKn | BEATS + 1 >= MAX_BURST). Next state OWN(other), BEATS <= 0, LAST <= n.
  - Otherwise stay in OWNn with BEATS <= min(BEATS+1, 15).
- OWNn with REQn = 0:
  - other REQ: go to OWN(other).
  - otherwise: go to IDLE.
  - In both cases BEATS <= 0 and LAST <= n.
- An uncontested owner streams back-to-back accesses indefinitely, with or without LOCK.
- LOCK is ignored when the other requester is idle, and ignored outside ownership.

## Timing
- Reset values: state IDLE, LAST = 1 (requester 0 wins the first tie), BEATS = 0, ACK0 = ACK1 = 0, RDATA0 = RDATA1 = 0. Combinational outputs: GNT = 0, OWNER = 00, M_MW = 0, M_ADDR = 0, M_DATA = 0.
- Latency from idle: REQ high in cycle t (state IDLE) → GNT in t+1 → accept at the end of t+1 → ACK/RDATA in t+2.
- Throughput: one access per cycle while owned. Handover has no bubble; the new owner's first accept is in the cycle after the handover edge.
- Requester rules:
  - Hold REQ, WE, ADDR, WDATA stable while REQn & ~GNTn.
  - May change them every cycle while GNTn is high; each high cycle is a separate access.
- Reset mid-burst: M_MW is forced to 0 in the reset cycle, so no write occurs. State returns to IDLE; a pending ACK clears.
- Simultaneous REQ0 and REQ1 in IDLE go to the ~LAST side. A contested, unlocked owner gets exactly one access per turn (strict alternation).

## Test plan
- Reset then single read:
  - Stimulus: RESET 2 cycles; REQ0 = 1, WE0 = 0, ADDR0 = 8'd4, memory holds 8'h17.
  - Required: GNT0 in cycle 2; ACK0 = 1 and RDATA0 = 8'h17 in cycle 3; all outputs 0 during reset.
- Contested unlocked access:
  - Stimulus: REQ0 and REQ1 held high from IDLE; requester 0 writes 8'hA5 to address 10, requester 1 reads address 10.
  - Required: OWNER 01, 10, 01, 10…; M_MW high only in OWN0 cycles; RDATA1 = 8'hA5 after the first write.
- Bounded lock:
  - Stimulus: MAX_BURST = 4; LOCK1 = REQ1 = 1 while REQ0 = 1.
  - Required: exactly 4 consecutive OWN1 accepts, then OWN0 for one access, then OWN1 again.
- IO path:
  - Stimulus: requester 1 writes 8'h3C to address 252.
  - Required: M_ADDR = 252, M_MW = 1 for one cycle; ACK1 next cycle.
  - Stimulus: requester 0 reads address 249 with the IO input = 8'h5A.
  - Required: RDATA0 = 8'h5A.
- Owner drops mid-burst plus reset:
  - Stimulus: REQ0 deasserts while in OWN0 with REQ1 low.
  - Required: IDLE next cycle; LAST = 0.
  - Stimulus: assert RESET during an OWN1 write cycle.
  - Required: M_MW = 0; memory location unchanged; state IDLE and ACK1 = 0 afterward.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one single-port 8-bit data memory / memory-mapped IO block between
// two bus masters: requester 0 (CPU datapath) and requester 1 (DMA or capture
// engine). Arbitration is round-robin. An owner may hold LOCK to keep the bus
// for a burst of at most MAX_BURST accepted accesses while the other side waits.
//
// Ports
//   CLK, RESET           clock, synchronous active-high reset
//   REQn/WEn/ADDRn/      request, write enable, address, write data and
//   WDATAn/LOCKn         burst lock from requester n
//   GNTn                 requester n owns the bus this cycle (from state)
//   ACKn                 registered: access accepted at the previous edge done
//   RDATAn               registered read data; holds between read accepts
//   M_ADDR/M_DATA/M_MW   memory address, write data, write enable
//   M_Q                  memory read data (combinational from M_ADDR)
//   OWNER                00 idle, 01 requester 0, 10 requester 1
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       WE0,
  input  logic       WE1,
  input  logic [7:0] ADDR0,
  input  logic [7:0] ADDR1,
  input  logic [7:0] WDATA0,
  input  logic [7:0] WDATA1,
  input  logic       LOCK0,
  input  logic       LOCK1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       ACK0,
  output logic       ACK1,
  output logic [7:0] RDATA0,
  output logic [7:0] RDATA1,
  output logic [7:0] M_ADDR,
  output logic [7:0] M_DATA,
  output logic       M_MW,
  input  logic [7:0] M_Q,
  output logic [1:0] OWNER
);

  // State encoding doubles as the OWNER output code.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_last;        // last owner; the other side wins the next tie
  logic       w_last_nxt;
  logic [3:0] r_beats;       // accepted accesses in the current tenure
  logic [3:0] w_beats_nxt;
  logic       r_ack0;
  logic       r_ack1;
  logic [7:0] r_rdata0;
  logic [7:0] r_rdata1;

  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_acc0;
  logic       w_acc1;
  logic       w_burst_done;
  logic [3:0] w_beats_sat;

  // Saturating beat increment so a long uncontested stream never wraps.
  function automatic logic [3:0] beats_inc_sat(input logic [3:0] beats);
    logic [3:0] res;
    if (beats == 4'd15) begin
      res = 4'd15;
    end else begin
      res = beats + 4'd1;
    end
    return res;
  endfunction

  assign w_gnt0 = (r_state == ST_OWN0);
  assign w_gnt1 = (r_state == ST_OWN1);
  assign w_acc0 = w_gnt0 & REQ0;
  assign w_acc1 = w_gnt1 & REQ1;

  // The lock budget is spent once the access being accepted now is the
  // MAX_BURST-th of this tenure.
  assign w_burst_done = (({1'b0, r_beats} + 5'd1) >= 5'(MAX_BURST));
  assign w_beats_sat  = beats_inc_sat(r_beats);

  // Next-state, LAST and BEATS decision.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_beats_nxt = r_beats;
    case (r_state)
      ST_IDLE: begin
        if (REQ0 & REQ1) begin
          w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
        end else if (REQ0) begin
          w_state_nxt = ST_OWN0;
        end else if (REQ1) begin
          w_state_nxt = ST_OWN1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OWN0: begin
        if (REQ0) begin
          if (REQ1 & (~LOCK0 | w_burst_done)) begin
            w_state_nxt = ST_OWN1;
            w_beats_nxt = 4'd0;
            w_last_nxt  = 1'b0;
          end else begin
            w_beats_nxt = w_beats_sat;
          end
        end else begin
          w_state_nxt = REQ1 ? ST_OWN1 : ST_IDLE;
          w_beats_nxt = 4'd0;
          w_last_nxt  = 1'b0;
        end
      end
      ST_OWN1: begin
        if (REQ1) begin
          if (REQ0 & (~LOCK1 | w_burst_done)) begin
            w_state_nxt = ST_OWN0;
            w_beats_nxt = 4'd0;
            w_last_nxt  = 1'b1;
          end else begin
            w_beats_nxt = w_beats_sat;
          end
        end else begin
          w_state_nxt = REQ0 ? ST_OWN0 : ST_IDLE;
          w_beats_nxt = 4'd0;
          w_last_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_beats_nxt = 4'd0;
        w_last_nxt  = 1'b1;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_beats <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_beats <= w_beats_nxt;
    end
  end

  // Registered completion: ACK pulses one cycle after each accept, read data
  // captured from the memory on read accepts and held otherwise.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= 8'd0;
      r_rdata1 <= 8'd0;
    end else begin
      r_ack0 <= w_acc0;
      r_ack1 <= w_acc1;
      if (w_acc0 & ~WE0) begin
        r_rdata0 <= M_Q;
      end
      if (w_acc1 & ~WE1) begin
        r_rdata1 <= M_Q;
      end
    end
  end

  // Memory address/data mux; an idle bus presents zeros.
  always_comb begin
    M_ADDR = 8'd0;
    M_DATA = 8'd0;
    case (r_state)
      ST_OWN0: begin
        M_ADDR = ADDR0;
        M_DATA = WDATA0;
      end
      ST_OWN1: begin
        M_ADDR = ADDR1;
        M_DATA = WDATA1;
      end
      default: begin
        M_ADDR = 8'd0;
        M_DATA = 8'd0;
      end
    endcase
  end

  // RESET gates the write strobe so a reset landing mid-burst never commits.
  assign M_MW   = ((w_gnt0 & REQ0 & WE0) | (w_gnt1 & REQ1 & WE1)) & ~RESET;
  assign GNT0   = w_gnt0;
  assign GNT1   = w_gnt1;
  assign OWNER  = r_state;
  assign ACK0   = r_ack0;
  assign ACK1   = r_ack1;
  assign RDATA0 = r_rdata0;
  assign RDATA1 = r_rdata1;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed scenarios followed by randomized traffic. The driver evaluates a
// turn-based reference arbiter each cycle and pushes the expected response of
// every accepted access into per-requester queues; a separate monitor pops and
// compares whenever the DUT acknowledges.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int MAXB = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
  logic [7:0] ADDR0 = 8'd0, ADDR1 = 8'd0, WDATA0 = 8'd0, WDATA1 = 8'd0;
  logic       LOCK0 = 1'b0, LOCK1 = 1'b0;
  logic       GNT0, GNT1, ACK0, ACK1, M_MW;
  logic [7:0] RDATA0, RDATA1, M_ADDR, M_DATA, M_Q;
  logic [1:0] OWNER;

  logic [7:0] mem     [0:255];   // memory/IO block seen by the DUT
  logic [7:0] mdl_mem [0:255];   // reference contents
  logic [8:0] q0[$];
  logic [8:0] q1[$];             // {is_read, expected data}
  logic [7:0] hold0 = 8'd0, hold1 = 8'd0;

  int m_owner = 0;               // 0 idle, 1 requester 0, 2 requester 1
  bit m_last  = 1'b1;
  int m_beats = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_bus_arbiter #(.MAX_BURST(MAXB)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .LOCK0(LOCK0), .LOCK1(LOCK1),
    .GNT0(GNT0), .GNT1(GNT1), .ACK0(ACK0), .ACK1(ACK1),
    .RDATA0(RDATA0), .RDATA1(RDATA1),
    .M_ADDR(M_ADDR), .M_DATA(M_DATA), .M_MW(M_MW), .M_Q(M_Q),
    .OWNER(OWNER)
  );

  assign M_Q = mem[M_ADDR];

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_mem(input int a, input logic [7:0] d);
    mem[a]     = d;
    mdl_mem[a] = d;
  endtask

  // Mid-cycle: check bus outputs against the reference, apply the memory
  // write, record the expected response and advance the reference arbiter.
  task automatic eval();
    logic [1:0] rq, wr, lk;
    logic [7:0] ea, ed;
    logic       emw;
    bit         n, o;
    #1;
    rq  = {REQ1, REQ0};
    wr  = {WE1, WE0};
    lk  = {LOCK1, LOCK0};
    n   = (m_owner == 2);
    o   = ~n;
    ea  = (m_owner == 0) ? 8'd0 : (n ? ADDR1 : ADDR0);
    ed  = (m_owner == 0) ? 8'd0 : (n ? WDATA1 : WDATA0);
    emw = (m_owner != 0) && rq[n] && wr[n] && !RESET;
    chk("owner", 32'(OWNER), 32'(m_owner));
    chk("gnt0", 32'(GNT0), 32'(m_owner == 1));
    chk("gnt1", 32'(GNT1), 32'(m_owner == 2));
    chk("m_addr", 32'(M_ADDR), 32'(ea));
    chk("m_data", 32'(M_DATA), 32'(ed));
    chk("m_mw", 32'(M_MW), 32'(emw));
    if (M_MW) mem[M_ADDR] = M_DATA;
    if (RESET) begin
      q0.delete();
      q1.delete();
      hold0   = 8'd0;
      hold1   = 8'd0;
      m_owner = 0;
      m_last  = 1'b1;
      m_beats = 0;
    end else if (m_owner == 0) begin
      if (rq[0] && rq[1]) m_owner = m_last ? 1 : 2;
      else if (rq[0])     m_owner = 1;
      else if (rq[1])     m_owner = 2;
    end else begin
      if (rq[n]) begin
        if (n) q1.push_back({~wr[n], mdl_mem[ea]});
        else   q0.push_back({~wr[n], mdl_mem[ea]});
        if (wr[n]) mdl_mem[ea] = ed;
        if (rq[o] && (!lk[n] || m_beats + 1 >= MAXB)) begin
          m_owner = o ? 2 : 1;
          m_beats = 0;
          m_last  = n;
        end else if (m_beats < 15) begin
          m_beats++;
        end
      end else begin
        m_beats = 0;
        m_last  = n;
        m_owner = rq[o] ? (o ? 2 : 1) : 0;
      end
    end
  endtask

  task automatic step();
    eval();
    @(negedge CLK);
  endtask

  // Monitor: after each rising edge, match acknowledgements to expectations.
  initial begin
    logic [8:0] e;
    forever begin
      @(posedge CLK);
      #1;
      chk("ack0", 32'(ACK0), 32'(q0.size() > 0));
      if (q0.size() > 0) begin
        e = q0.pop_front();
        if (e[8]) hold0 = e[7:0];
      end
      chk("rdata0", 32'(RDATA0), 32'(hold0));
      chk("ack1", 32'(ACK1), 32'(q1.size() > 0));
      if (q1.size() > 0) begin
        e = q1.pop_front();
        if (e[8]) hold1 = e[7:0];
      end
      chk("rdata1", 32'(RDATA1), 32'(hold1));
    end
  end

  initial begin
    int exp2 [6];
    int exp3 [6];
    exp2 = '{0, 1, 2, 1, 2, 1};
    exp3 = '{2, 2, 2, 2, 1, 2};
    for (int i = 0; i < 256; i++) set_mem(i, 8'(i * 7 + 3));
    set_mem(4, 8'h17);

    // Reset, then a single read from idle.
    @(negedge CLK);
    step();
    step();
    RESET = 1'b0; REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 8'd4;
    step();
    eval();
    chk("t1_gnt0", 32'(GNT0), 32'd1);
    @(negedge CLK);
    REQ0 = 1'b0;
    chk("t1_ack0", 32'(ACK0), 32'd1);
    chk("t1_rdata0", 32'(RDATA0), 32'h17);
    step();

    // Contested, unlocked: strict alternation starting with requester 0.
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    set_mem(10, 8'h00);
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 8'd10; WDATA0 = 8'hA5;
    REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 8'd10;
    for (int i = 0; i < 6; i++) begin
      eval();
      chk("t2_owner", 32'(OWNER), 32'(exp2[i]));
      chk("t2_mw", 32'(M_MW), 32'(exp2[i] == 1));
      @(negedge CLK);
    end
    REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0;
    chk("t2_rdata1", 32'(RDATA1), 32'hA5);
    step();

    // Bounded lock: requester 1 keeps four accepts, then one for requester 0.
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    REQ1 = 1'b1; LOCK1 = 1'b1; WE1 = 1'b0; ADDR1 = 8'd10;
    step();
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 8'd10; LOCK0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      eval();
      chk("t3_owner", 32'(OWNER), 32'(exp3[i]));
      @(negedge CLK);
    end
    REQ0 = 1'b0; REQ1 = 1'b0; LOCK1 = 1'b0;
    step();

    // IO path: requester 1 writes 252, requester 0 reads 249.
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    set_mem(252, 8'h00);
    REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 8'd252; WDATA1 = 8'h3C;
    step();
    eval();
    chk("t4_maddr", 32'(M_ADDR), 32'd252);
    chk("t4_mw", 32'(M_MW), 32'd1);
    @(negedge CLK);
    REQ1 = 1'b0; WE1 = 1'b0;
    eval();
    chk("t4_ack1", 32'(ACK1), 32'd1);
    chk("t4_mw_off", 32'(M_MW), 32'd0);
    chk("t4_mem252", 32'(mem[252]), 32'h3C);
    @(negedge CLK);
    set_mem(249, 8'h5A);
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 8'd249;
    step();
    step();
    REQ0 = 1'b0;
    chk("t4_rdata0", 32'(RDATA0), 32'h5A);
    step();

    // Owner drops mid-burst, then reset during a requester 1 write.
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 8'd5;
    step();
    step();
    step();
    REQ0 = 1'b0;
    eval();
    chk("t5_own0", 32'(OWNER), 32'd1);
    @(negedge CLK);
    eval();
    chk("t5_idle", 32'(OWNER), 32'd0);
    @(negedge CLK);
    set_mem(20, 8'h11);
    REQ0 = 1'b1; REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 8'd20; WDATA1 = 8'h99;
    step();
    RESET = 1'b1;
    eval();
    chk("t5_tie_own1", 32'(OWNER), 32'd2);
    chk("t5_rst_mw", 32'(M_MW), 32'd0);
    @(negedge CLK);
    RESET = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; WE1 = 1'b0;
    eval();
    chk("t5_post_idle", 32'(OWNER), 32'd0);
    chk("t5_post_ack1", 32'(ACK1), 32'd0);
    chk("t5_mem20", 32'(mem[20]), 32'h11);
    @(negedge CLK);

    // Randomized traffic on a small address window to stress read-after-write.
    for (int i = 0; i < 3000; i++) begin
      RESET  = ($urandom_range(0, 199) == 0);
      REQ0   = ($urandom_range(0, 3) != 0);
      REQ1   = ($urandom_range(0, 3) != 0);
      WE0    = $urandom_range(0, 1) != 0;
      WE1    = $urandom_range(0, 1) != 0;
      LOCK0  = $urandom_range(0, 1) != 0;
      LOCK1  = $urandom_range(0, 1) != 0;
      ADDR0  = 8'($urandom_range(0, 15));
      ADDR1  = 8'($urandom_range(0, 15));
      WDATA0 = 8'($urandom_range(0, 255));
      WDATA1 = 8'($urandom_range(0, 255));
      step();
    end

    RESET = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
